// File: rtl/serial_add_sched_if.sv
// rtl/serial_add_sched_if.sv - two job request channels and one response channel of the shared adder
// The slave side is the scheduler; the master side is the requesters plus the result consumer.
interface serial_add_sched_if #(
    parameter int WIDTH = 256
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_cin;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_cin;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_sum;
    logic             rsp_cout;

    modport master (
        output req0_valid, req0_a, req0_b, req0_cin,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_cin,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_sum, rsp_cout,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_cin,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_sum, rsp_cout,
        input  rsp_ready
    );
endinterface

// File: rtl/serial_add_sched.sv
// rtl/serial_add_sched.sv - round-robin scheduler around a shared chunk-serial adder
// One job in flight: accept, WIDTH/CHUNK add cycles LSB chunk first, then hold the result until taken.
module serial_add_sched #(
    parameter int WIDTH = 256,
    parameter int CHUNK = 8
) (
    input  logic              clk,
    input  logic              rst,
    serial_add_sched_if.slave bus,
    output logic              busy
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;
    state_t state, state_nx;

    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic             carry_q, cout_q, id_q, last_grant_q;
    logic [CW-1:0]    cnt_q;

    logic             grant, any_valid, accept;
    logic [CHUNK:0]   slice;
    logic [WIDTH-1:0] sum_nx;

    assign any_valid = bus.req0_valid | bus.req1_valid;
    // With both pending the requester that did not win last time goes next.
    assign grant = (bus.req0_valid & bus.req1_valid) ? ~last_grant_q : bus.req1_valid;

    assign slice  = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
    // New chunk enters at the top so after N cycles the LSB chunk has reached bit 0.
    assign sum_nx = (sum_q >> CHUNK) | (WIDTH'(slice[CHUNK-1:0]) << (WIDTH - CHUNK));

    always_comb begin
        state_nx       = state;
        accept         = 1'b0;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        case (state)
            IDLE: begin
                if (!rst && any_valid) begin
                    accept         = 1'b1;
                    bus.req0_ready = ~grant;
                    bus.req1_ready = grant;
                    state_nx       = RUN;
                end
            end
            RUN: begin
                if (cnt_q == LAST) state_nx = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            sum_q        <= '0;
            carry_q      <= 1'b0;
            cout_q       <= 1'b0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q          <= grant ? bus.req1_a : bus.req0_a;
                        b_q          <= grant ? bus.req1_b : bus.req0_b;
                        carry_q      <= grant ? bus.req1_cin : bus.req0_cin;
                        id_q         <= grant;
                        last_grant_q <= grant;
                        cnt_q        <= '0;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> CHUNK;
                    b_q     <= b_q >> CHUNK;
                    sum_q   <= sum_nx;
                    carry_q <= slice[CHUNK];
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == LAST) cout_q <= slice[CHUNK];
                end
                default: ;
            endcase
        end
    end

    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_sum   = sum_q;
    assign bus.rsp_cout  = cout_q;
    assign bus.rsp_id    = id_q;
    assign busy          = (state != IDLE);
endmodule

// File: tb/tb_serial_add_sched.sv
// tb/tb_serial_add_sched.sv - randomized self-checking bench for serial_add_sched
`timescale 1ns/1ps
module tb_serial_add_sched;
    localparam int W = 256;
    localparam int C = 8;
    localparam int N = W / C;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    int   checks = 0;
    int   errors = 0;
    logic id_log[$];

    serial_add_sched_if #(.WIDTH(W)) sif();
    serial_add_sched #(.WIDTH(W), .CHUNK(C)) dut (.clk(clk), .rst(rst), .bus(sif.slave), .busy(busy));

    always #5 clk = ~clk;

    logic [W-1:0] sw_a, sw_b;
    logic         sw_cin;
    logic         sweep_go = 1'b0;
    int           sw_lat [3];
    logic [W:0]   sw_res [3];
    logic         sw_id  [3];
    logic         sw_rdy [3];
    logic         sw_done[3];
    logic [2:0]   sw_busy;

    for (genvar g = 0; g < 3; g++) begin : sw
        localparam int CH = (g == 0) ? 1 : (g == 1) ? 64 : 256;
        int         lat = 0;
        logic [W:0] res = '0;
        logic       idv = 1'b0, rdy = 1'b0, done = 1'b0;
        serial_add_sched_if #(.WIDTH(W)) sif_s();
        serial_add_sched #(.WIDTH(W), .CHUNK(CH)) dut_s (
            .clk(clk), .rst(rst), .bus(sif_s.slave), .busy(sw_busy[g]));
        assign sw_lat[g]  = lat;
        assign sw_res[g]  = res;
        assign sw_id[g]   = idv;
        assign sw_rdy[g]  = rdy;
        assign sw_done[g] = done;
        initial begin
            sif_s.req0_valid = 0; sif_s.req0_a = '0; sif_s.req0_b = '0; sif_s.req0_cin = 0;
            sif_s.req1_valid = 0; sif_s.req1_a = '0; sif_s.req1_b = '0; sif_s.req1_cin = 0;
            sif_s.rsp_ready  = 0;
            wait (sweep_go);
            @(posedge clk); #1;
            sif_s.req0_a = sw_a; sif_s.req0_b = sw_b; sif_s.req0_cin = sw_cin;
            sif_s.req0_valid = 1;
            #1;
            rdy = sif_s.req0_ready && !sif_s.req1_ready;
            @(posedge clk); #1;
            sif_s.req0_valid = 0;
            while (!sif_s.rsp_valid && lat < 400) begin
                @(posedge clk); #1;
                lat++;
            end
            res = {sif_s.rsp_cout, sif_s.rsp_sum};
            idv = sif_s.rsp_id;
            sif_s.rsp_ready = 1;
            @(posedge clk); #1;
            sif_s.rsp_ready = 0;
            done = 1;
        end
    end

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    endfunction

    task automatic idle_inputs();
        sif.req0_valid = 0; sif.req0_a = '0; sif.req0_b = '0; sif.req0_cin = 0;
        sif.req1_valid = 0; sif.req1_a = '0; sif.req1_b = '0; sif.req1_cin = 0;
        sif.rsp_ready  = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({sif.rsp_valid, sif.rsp_id, sif.rsp_cout, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000", {sif.rsp_valid, sif.rsp_id, sif.rsp_cout, busy});
        end
        checks++;
        if (sif.rsp_sum !== '0) begin
            errors++; $display("FAIL reset_sum: got %h expected 0", sif.rsp_sum);
        end
        sif.req0_valid = 1; sif.req1_valid = 1;
        #1;
        checks++;
        if ({sif.req0_ready, sif.req1_ready} !== 2'b10) begin
            errors++; $display("FAIL reset_first_grant: got %b expected 10", {sif.req0_ready, sif.req1_ready});
        end
        rst = 1;
        #1;
        checks++;
        if ({sif.req0_ready, sif.req1_ready} !== 2'b00) begin
            errors++; $display("FAIL ready_in_reset: got %b expected 00", {sif.req0_ready, sif.req1_ready});
        end
        idle_inputs();
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic test_single();
        int lat;
        sif.req0_a = '1; sif.req0_b = 1; sif.req0_cin = 0; sif.req0_valid = 1;
        #1;
        checks++;
        if (sif.req0_ready !== 1'b1) begin
            errors++; $display("FAIL single_ready: got %b expected 1", sif.req0_ready);
        end
        @(posedge clk); #1;
        sif.req0_valid = 0; sif.req0_a = rand_w(); sif.req0_b = rand_w();
        lat = 0;
        while (!sif.rsp_valid && lat < N + 10) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat != N) begin
            errors++; $display("FAIL single_latency: got %0d expected %0d", lat, N);
        end
        checks++;
        if ({sif.rsp_id, sif.rsp_cout, sif.rsp_sum} !== {1'b0, 1'b1, {W{1'b0}}}) begin
            errors++; $display("FAIL single_result: got id %b cout %b sum %h expected id 0 cout 1 sum 0",
                               sif.rsp_id, sif.rsp_cout, sif.rsp_sum);
        end
        sif.rsp_ready = 1;
        @(posedge clk); #1;
        sif.rsp_ready = 0;
        checks++;
        if ({sif.rsp_valid, busy, sif.rsp_cout} !== 3'b001 || sif.rsp_sum !== '0) begin
            errors++; $display("FAIL single_after_handshake: got valid %b busy %b cout %b expected 0 0 1",
                               sif.rsp_valid, busy, sif.rsp_cout);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [W:0] exp;
        do_reset();
        sif.req1_a = rand_w(); sif.req1_b = rand_w(); sif.req1_cin = 1'($urandom);
        exp = ref_add(sif.req1_a, sif.req1_b, sif.req1_cin);
        sif.req1_valid = 1;
        #1;
        checks++;
        if ({sif.req0_ready, sif.req1_ready} !== 2'b01) begin
            errors++; $display("FAIL bp_grant: got %b expected 01", {sif.req0_ready, sif.req1_ready});
        end
        @(posedge clk); #1;
        sif.req1_valid = 0;
        lat = 0;
        while (!sif.rsp_valid && lat < N + 10) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat != N) begin
            errors++; $display("FAIL bp_latency: got %0d expected %0d", lat, N);
        end
        sif.req0_valid = 1; sif.req1_valid = 1;
        #1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({sif.rsp_valid, sif.rsp_id, busy, sif.req0_ready, sif.req1_ready} !== 5'b11100 ||
                {sif.rsp_cout, sif.rsp_sum} !== exp) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: got v/id/busy/rdy %b result %h expected 11100 result %h",
                         i, {sif.rsp_valid, sif.rsp_id, busy, sif.req0_ready, sif.req1_ready},
                         {sif.rsp_cout, sif.rsp_sum}, exp);
            end
            @(posedge clk); #1;
        end
        sif.req0_valid = 0; sif.req1_valid = 0; sif.rsp_ready = 1;
        @(posedge clk); #1;
        sif.rsp_ready = 0;
        checks++;
        if ({sif.rsp_valid, busy} !== 2'b00) begin
            errors++; $display("FAIL bp_release: got valid %b busy %b expected 0 0", sif.rsp_valid, busy);
        end
    endtask

    task automatic test_reset_mid();
        int lat, seen;
        do_reset();
        sif.req1_a = rand_w(); sif.req1_b = rand_w(); sif.req1_cin = 1; sif.req1_valid = 1;
        @(posedge clk); #1;
        sif.req1_valid = 0;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL mid_busy_before: got %b expected 1", busy);
        end
        sif.req0_valid = 1; sif.req1_valid = 1; rst = 1;
        #1;
        checks++;
        if ({sif.rsp_valid, sif.rsp_id, sif.rsp_cout, busy, sif.req0_ready, sif.req1_ready} !== 6'b0 ||
            sif.rsp_sum !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got flags %b sum %h expected all 0",
                     {sif.rsp_valid, sif.rsp_id, sif.rsp_cout, busy, sif.req0_ready, sif.req1_ready}, sif.rsp_sum);
        end
        idle_inputs();
        @(posedge clk); #1;
        rst = 0;
        sif.rsp_ready = 1;
        seen = 0;
        for (int i = 0; i < N + 5; i++) begin
            if (sif.rsp_valid || busy) seen++;
            @(posedge clk); #1;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL mid_no_response: got %0d active cycles expected 0", seen);
        end
        sif.rsp_ready = 0;
        sif.req1_a = 5; sif.req1_b = 3; sif.req1_cin = 1; sif.req1_valid = 1;
        @(posedge clk); #1;
        sif.req1_valid = 0;
        lat = 0;
        while (!sif.rsp_valid && lat < N + 10) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat != N || sif.rsp_sum !== W'(9) || sif.rsp_cout !== 1'b0 || sif.rsp_id !== 1'b1) begin
            errors++;
            $display("FAIL mid_resubmit: got lat %0d sum %h cout %b id %b expected lat %0d sum 9 cout 0 id 1",
                     lat, sif.rsp_sum, sif.rsp_cout, sif.rsp_id, N);
        end
        sif.rsp_ready = 1;
        @(posedge clk); #1;
        sif.rsp_ready = 0;
    endtask

    // Transaction-level model: one job outstanding, result due N+1 cycles after the accept cycle.
    task automatic run_traffic(input int jobs, input int pv, input int pr, input bit hold);
        logic [W-1:0] a0, b0, a1, b1;
        logic         c0, c1, v0, v1, eg, er0, er1, ev, out, last;
        logic [W:0]   expq[$];
        logic         idq[$];
        int           done, cyc, acc_cyc, limit;
        a0 = rand_w(); b0 = rand_w(); c0 = 1'($urandom);
        a1 = rand_w(); b1 = rand_w(); c1 = 1'($urandom);
        out = 0; last = 1; done = 0; cyc = 0; acc_cyc = 0;
        limit = jobs * (N + 2) * 8 + 200;
        id_log.delete();
        while (done < jobs && cyc < limit) begin
            v0 = hold || ($urandom_range(99) < pv);
            v1 = hold || ($urandom_range(99) < pv);
            sif.req0_valid = v0; sif.req0_a = a0; sif.req0_b = b0; sif.req0_cin = c0;
            sif.req1_valid = v1; sif.req1_a = a1; sif.req1_b = b1; sif.req1_cin = c1;
            sif.rsp_ready = ($urandom_range(99) < pr);
            #1;
            eg  = (v0 && v1) ? !last : v1;
            er0 = !out && (v0 || v1) && !eg;
            er1 = !out && (v0 || v1) && eg;
            ev  = out && (cyc - acc_cyc > N);
            checks++;
            if ({sif.req0_ready, sif.req1_ready} !== {er0, er1}) begin
                errors++;
                $display("FAIL traffic_ready cyc %0d: got %b expected %b", cyc,
                         {sif.req0_ready, sif.req1_ready}, {er0, er1});
            end
            checks++;
            if (sif.rsp_valid !== ev) begin
                errors++; $display("FAIL traffic_rsp_valid cyc %0d: got %b expected %b", cyc, sif.rsp_valid, ev);
            end
            if (ev && sif.rsp_ready) begin
                checks++;
                if ({sif.rsp_cout, sif.rsp_sum} !== expq[0] || sif.rsp_id !== idq[0]) begin
                    errors++;
                    $display("FAIL traffic_result job %0d: got id %b %h expected id %b %h", done,
                             sif.rsp_id, {sif.rsp_cout, sif.rsp_sum}, idq[0], expq[0]);
                end
                void'(expq.pop_front());
                void'(idq.pop_front());
                done++;
                out = 0;
            end else if (!out && (v0 || v1)) begin
                expq.push_back(eg ? ref_add(a1, b1, c1) : ref_add(a0, b0, c0));
                idq.push_back(eg);
                id_log.push_back(eg);
                last = eg; out = 1; acc_cyc = cyc;
                if (eg) begin a1 = rand_w(); b1 = rand_w(); c1 = 1'($urandom); end
                else    begin a0 = rand_w(); b0 = rand_w(); c0 = 1'($urandom); end
            end
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (done != jobs) begin
            errors++; $display("FAIL traffic_timeout: got %0d responses expected %0d", done, jobs);
        end
        idle_inputs();
    endtask

    task automatic test_contention();
        logic exp_g;
        do_reset();
        run_traffic(8, 100, 100, 1'b1);
        checks++;
        if (id_log.size() != 8) begin
            errors++; $display("FAIL contention_count: got %0d expected 8", id_log.size());
        end
        for (int i = 0; i < 8 && i < id_log.size(); i++) begin
            exp_g = (i % 2) == 1;
            checks++;
            if (id_log[i] !== exp_g) begin
                errors++; $display("FAIL contention_order job %0d: got %b expected %b", i, id_log[i], exp_g);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        run_traffic(200, 50, 60, 1'b0);
    endtask

    task automatic test_param_sweep();
        int t, ch;
        sw_a = rand_w(); sw_b = ~sw_a; sw_cin = 1;
        sweep_go = 1;
        t = 0;
        while (!(sw_done[0] && sw_done[1] && sw_done[2]) && t < 1000) begin
            @(posedge clk); #1;
            t++;
        end
        checks++;
        if (!(sw_done[0] && sw_done[1] && sw_done[2])) begin
            errors++; $display("FAIL sweep_timeout: got done %b%b%b expected 111", sw_done[0], sw_done[1], sw_done[2]);
        end
        for (int g = 0; g < 3; g++) begin
            ch = (g == 0) ? 1 : (g == 1) ? 64 : 256;
            checks++;
            if (sw_lat[g] != W / ch) begin
                errors++; $display("FAIL sweep_latency chunk %0d: got %0d expected %0d", ch, sw_lat[g], W / ch);
            end
            checks++;
            if (sw_res[g] !== ref_add(sw_a, sw_b, sw_cin) || sw_rdy[g] !== 1'b1 || sw_id[g] !== 1'b0 ||
                sw_busy[g] !== 1'b0) begin
                errors++;
                $display("FAIL sweep_result chunk %0d: got %h rdy %b id %b busy %b expected %h rdy 1 id 0 busy 0",
                         ch, sw_res[g], sw_rdy[g], sw_id[g], sw_busy[g], ref_add(sw_a, sw_b, sw_cin));
            end
        end
    endtask

    initial begin
        idle_inputs();
        do_reset();
        test_reset();
        test_single();
        test_backpressure();
        test_reset_mid();
        test_contention();
        test_random();
        test_param_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_add_sched.md
Name: serial_add_sched

Overview:
- Shares one chunk-serial adder between two requesters, each of which submits WIDTH-bit add jobs.
- Arbitrates round-robin, captures the winner's operands and sequences the add at CHUNK bits per cycle, LSB chunk first.
- Returns {cout, sum} with the requester ID over a valid/ready response channel.
- Sits between multi-client arithmetic users and the serial adder datapath, which is embedded here as a CHUNK-bit slice.

Parameters:
- WIDTH, 256: operand/sum width; must be a multiple of CHUNK.
- CHUNK, 8: bits added per RUN cycle; N = WIDTH/CHUNK RUN cycles per job.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- req0_valid  input  1  requester 0 job present
- req0_ready  output  1  requester 0 job accepted this edge if valid
- req0_a  input  WIDTH  requester 0 operand A
- req0_b  input  WIDTH  requester 0 operand B
- req0_cin  input  1  requester 0 carry-in
- req1_valid, req1_ready, req1_a, req1_b, req1_cin: same as requester 0, for requester 1
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer takes result
- rsp_id  output  1  requester that owns the result
- rsp_sum  output  WIDTH  sum bits
- rsp_cout  output  1  carry-out of bit WIDTH-1
- busy  output  1  high in RUN or RESP

Behaviour:
- One clock domain. Reset is asynchronous and active-high: rst high immediately forces state=IDLE, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, busy=0, chunk counter=0, last_grant=1 (so requester 0 wins first).
- req0_ready and req1_ready are 0 whenever rst is high.
- FSM states: IDLE, RUN, RESP.
- IDLE arbitration (combinational, single winner):
  - If only one requester is valid, it is granted.
  - If both are valid, the one not equal to last_grant is granted.
  - reqX_ready=1 only for the granted requester, and only in IDLE; it may depend combinationally on reqX_valid.
- Accept edge (IDLE, valid&&ready): register A, B and cin into the carry flop; id=granted; last_grant=granted; counter=0; next state RUN.
- RUN, each cycle:
  - {c, s} = A[CHUNK-1:0] + B[CHUNK-1:0] + carry, computed as a CHUNK+1-bit result.
  - Shift the sum register right by CHUNK, inserting s at the top.
  - Shift A and B right by CHUNK; carry=c; counter++.
  - When counter==N-1 at an edge, next state is RESP.
- Latency: rsp_valid rises exactly N cycles after the accept edge (N=32 at defaults).
- RESP:
  - rsp_valid=1; rsp_sum, rsp_cout and rsp_id hold stable until rsp_ready.
  - On the edge with rsp_valid&&rsp_ready, go to IDLE with rsp_valid=0. rsp_sum, rsp_cout and rsp_id keep their last values.
  - No request is accepted in RUN or RESP, i.e. both readies are 0.
- Throughput: at most one job per N+2 cycles (accept, N RUN cycles, one response edge, back to IDLE).
- Input operands are sampled only on the accept edge; later changes on reqX_a/b are ignored.
- Overflow: rsp_cout is the true carry out, so {rsp_cout, rsp_sum} == a+b+cin modulo 2^(WIDTH+1).
- A reqX_valid that drops before it is granted is not an error; nothing is captured.
- rst asserted mid-RUN or mid-RESP: the job is discarded, no response is produced, and the requester must resubmit.
- N=1 (CHUNK=WIDTH) is legal: RUN lasts one cycle.

Test Plan:
- Single job: req0 with a=all ones, b=1, cin=0 -> rsp_valid rises exactly 32 cycles after the accept edge, with rsp_sum=0, rsp_cout=1, rsp_id=0.
- Contention: both requesters valid from reset release with distinct jobs -> req0 is accepted first and req1 second. Responses arrive with rsp_id order 0 then 1. With both requesters continuously valid, grants alternate 0,1,0,1 over 8 jobs.
- Backpressure: rsp_ready held low for 5 cycles in RESP -> rsp_valid, rsp_sum, rsp_cout and rsp_id are stable throughout, both readies stay 0, and busy=1. The response handshake completes on the first cycle rsp_ready=1.
- Reset mid-operation: rst pulsed during RUN cycle 10 -> all outputs are 0 immediately and no response appears. A resubmitted job a=0x5, b=0x3, cin=1 then returns rsp_sum=0x9, rsp_cout=0.
- Random regression: 200 jobs with random a, b, cin and random requester validity -> every response matches a+b+cin, including bit WIDTH carried into rsp_cout. Every rsp_id matches its submitter in order.
- Parameter sweep: CHUNK=1, 64 and 256 with WIDTH=256 -> latency is WIDTH/CHUNK cycles and results are correct.
